rr_arb8: RTL and testbench
==========================

// Module: rr_arb8
// PURPOSE
// - Round-robin arbiter sharing one 8:1 one-hot-select mux (k-bit datapath) among 8 requesters.
// - Drives the mux one-hot select directly from a registered grant, so the select is never
//   multi-hot and never glitches.
// - Supports burst hold with a bounded burst length, then rotates for fairness.
// - Sits between the 8 requesting sources and the shared mux/consumer.
// PARAMETERS
// - MAXBURST  8  max consecutive grant cycles while another requester waits; 0 = unlimited.
// - CW        4  burst counter width; MAXBURST must be <= 2**CW-1.
// PORTS
// - clk    in   1  single clock, rising edge.
// - rst    in   1  asynchronous, active-high reset.
// - req    in   8  request per source; held high for the whole transfer.
// - gnt    out  8  registered one-hot grant or 0; wired to the mux select input.
// - gidx   out  3  binary index of gnt; 0 when gnt==0.
// - busy   out  1  gnt != 0.
// BEHAVIOUR
// - Reset (async, immediate):
//   - gnt=0, gidx=0, busy=0, ptr=0, cnt=0, state=IDLE.
//   - Outputs go to 0 within the reset cycle; there is no wait for a clock edge.
// - State IDLE (gnt=0):
//   - If req!=0, pick the first set req bit at or after ptr, scanning circularly upward (7 wraps to 0).
//   - Next cycle gnt=onehot(pick), cnt=1, state=GRANT. Latency req->gnt is 1 clk.
// - State GRANT (gnt=onehot(i)):
//   - req[i] still high, and MAXBURST==0 or cnt<MAXBURST or no other req pending:
//     - gnt holds; cnt increments and saturates at 2**CW-1.
//   - req[i] low (release):
//     - ptr=i+1 mod 8.
//     - If any req pending, next cycle gnt=onehot(pick from ptr), with no idle bubble, and cnt=1.
//     - Otherwise gnt=0 and state=IDLE.
//   - req[i] high, cnt==MAXBURST (MAXBURST!=0), and another req pending (preemption):
//     - ptr=i+1.
//     - Next cycle gnt moves to pick(req & ~onehot(i)) from ptr; cnt=1.
//     - Requester i observes the grant loss and re-competes.
// - Invariants:
//   - gnt is always zero or one-hot, so the mux default (X) case is never selected.
//   - gnt changes only on clk edges or on rst.
// - Simultaneous events:
//   - Release and new requests in the same cycle: the pick excludes i because req[i]=0.
//   - A req bit that rises and falls while not granted is ignored. There is no latching;
//     requesters must hold req.
// - Pointer:
//   - Updates only on release or preemption; not on the initial IDLE grant.
//   - Wrap: 7+1 -> 0.
// - Reset mid-grant: the transfer is aborted, all state clears, and arbitration restarts from ptr=0.
// STRUCTURE
// - Shared package/include rr_arb_pkg:
//   - IDLE/GRANT state encoding.
//   - NREQ=8.
//   - function onehot_to_idx3.
// - Sub-module rr_pick8: combinational circular priority pick.
//   - Inputs: req[7:0], ptr[2:0].
//   - Outputs: pick_oh[7:0], pick_vld.
//   - Instantiated once, with a masked-request input for preemption.
// - The top level holds the state register, ptr, cnt, the gnt register and the gidx/busy decode.
// TESTING
// - Reset with req=8'h00 -> gnt=8'h00, gidx=0, busy=0; assert rst mid-run -> gnt=0 the same cycle.
// - ptr=0, req=8'h05 -> gnt=8'h01 after 1 clk; drop req[0] -> next clk gnt=8'h04 (no bubble), ptr=1.
// - MAXBURST=4, req=8'hFF held -> gnt=01 for 4 clks, then 02,04,08,10,20,40,80,01, each 4 clks (wrap checked).
// - MAXBURST=4, only req[3] held 20 clks -> gnt=8'h08 all 20 clks; no preemption, cnt saturates.
// - Grant on req[6], then release with req=8'h41 -> pick from ptr=7 wraps -> gnt=8'h01.
// - Random req for 10k clks -> gnt always one-hot or 0, and no waiting requester starves beyond 7*MAXBURST+7 clks.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// state encoding and the one-hot to index decode.
package rr_arb_pkg;

    localparam int NREQ = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    function automatic logic [2:0] onehot_to_idx3(input logic [NREQ-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = idx | i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational circular priority pick: first set request at or above ptr,
// wrapping from 7 back to 0.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] pick_oh,
    output logic            pick_vld
);

    logic [2:0] idx;

    always_comb begin
        pick_oh  = '0;
        pick_vld = 1'b0;
        idx      = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + k[2:0];
            if (!pick_vld && req[idx]) begin
                pick_oh[idx] = 1'b1;
                pick_vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for 8 requesters with bounded burst hold; the
// registered one-hot grant drives a shared mux select directly.
module rr_arb8
    import rr_arb_pkg::*;
#(
    parameter int MAXBURST = 8,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gidx,
    output logic            busy
);

    localparam logic [CW-1:0] MAXB    = CW'(MAXBURST);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [0:0]      state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic [2:0]      cur_idx;
    logic [2:0]      pick_ptr;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_oh;
    logic            pick_vld;
    logic            burst_done;
    logic            owner_req;

    assign cur_idx = onehot_to_idx3(gnt_q);

    // Masking the current owner makes the same pick serve release (its req is
    // already low) and preemption (it must be skipped); in IDLE gnt_q is zero.
    assign pick_req   = req & ~gnt_q;
    assign pick_ptr   = (state_q == GRANT) ? (cur_idx + 3'd1) : ptr_q;
    assign owner_req  = |(req & gnt_q);
    assign burst_done = (MAXBURST != 0) && (cnt_q >= MAXB);

    rr_pick8 u_pick (
        .req      (pick_req),
        .ptr      (pick_ptr),
        .pick_oh  (pick_oh),
        .pick_vld (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_oh;
                    cnt_d   = CNT_ONE;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    ptr_d = cur_idx + 3'd1;
                    if (pick_vld) begin
                        gnt_d = pick_oh;
                        cnt_d = CNT_ONE;
                    end else begin
                        gnt_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (burst_done && pick_vld) begin
                    ptr_d = cur_idx + 3'd1;
                    gnt_d = pick_oh;
                    cnt_d = CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign gidx = cur_idx;
    assign busy = |gnt_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed scenarios plus random holding requesters,
// all checked against a rule-level arbiter model.
module tb_rr_arb8;

    localparam int MB    = 4;
    localparam int CMAX  = 15;
    localparam int BOUND = 7 * MB + 7;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gidx;
    logic       busy;

    int errors;
    int checks;

    int m_owner;
    int m_ptr;
    int m_cnt;

    int hold  [8];
    int waitc [8];

    rr_arb8 #(.MAXBURST(MB), .CW(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .gidx (gidx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] others;
        if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            if (m_owner >= 0) m_cnt = 1;
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = pick(r, m_ptr);
            m_cnt   = 1;
        end else begin
            others = r & ~(8'h01 << m_owner);
            if (others == 8'h00 || m_cnt < MB) begin
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = pick(others, m_ptr);
                m_cnt   = 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".gidx"}, 32'(gidx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    endtask

    task automatic tick(input string tag);
        model_step(req);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        req    = 8'h00;
        rst    = 1'b1;
        model_reset();
        #3;
        chk("reset.gnt", 32'(gnt), 32'h0);
        chk("reset.gidx", 32'(gidx), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick("idle");

        // First grant, then release with another request pending: no bubble.
        req = 8'h05;
        tick("req05");
        chk("req05.first", 32'(gnt), 32'h01);
        req = 8'h04;
        tick("rel0");
        chk("rel0.next", 32'(gnt), 32'h04);
        req = 8'h00;
        tick("rel2");

        // All requesting: four cycles each, rotating through 7 back to 0.
        do_reset();
        req = 8'hFF;
        for (int t = 0; t < 36; t++) begin
            tick("allreq");
            chk("allreq.seq", 32'(gnt), 32'(8'h01 << ((t / 4) % 8)));
        end

        // Asynchronous reset mid-grant clears outputs before any edge.
        rst = 1'b1;
        #1;
        chk("midrst.gnt", 32'(gnt), 32'h0);
        chk("midrst.gidx", 32'(gidx), 32'h0);
        chk("midrst.busy", 32'(busy), 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
        tick("postrst");
        chk("postrst.gnt", 32'(gnt), 32'h01);

        // Lone requester is never preempted, even past counter saturation.
        do_reset();
        req = 8'h08;
        for (int t = 0; t < 20; t++) begin
            tick("lone3");
            chk("lone3.hold", 32'(gnt), 32'h08);
        end

        // Release of requester 6 picks from 7, wrapping to 0.
        do_reset();
        req = 8'h40;
        tick("g6");
        req = 8'h41;
        tick("g6hold");
        chk("g6hold.gnt", 32'(gnt), 32'h40);
        req = 8'h01;
        tick("wrap");
        chk("wrap.gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        tick("wrapidle");

        // Random holding requesters.
        do_reset();
        req = 8'h00;
        for (int i = 0; i < 8; i++) begin
            hold[i]  = 0;
            waitc[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            int maxw;
            for (int i = 0; i < 8; i++) begin
                if (m_owner == i) begin
                    if (hold[i] == 0) hold[i] = int'($urandom_range(1, 10));
                    hold[i]--;
                    if (hold[i] == 0) req[i] = 1'b0;
                end else if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                end
            end
            tick("rand");
            checks++;
            assert ($onehot0(gnt)) else begin
                errors++;
                $error("FAIL rand.onehot: got %0h expected one-hot or zero", gnt);
            end
            maxw = 0;
            for (int i = 0; i < 8; i++) begin
                if (req[i] && !gnt[i]) waitc[i]++;
                else waitc[i] = 0;
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            checks++;
            assert (maxw <= BOUND) else begin
                errors++;
                $error("FAIL rand.starve: got wait %0d expected <= %0d", maxw, BOUND);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
